// File: rtl/ifetch_pkg.sv
// Shared types and default sizes for the instruction prefetch stage.
package ifetch_pkg;
    localparam int DEF_DATA_W = 32;
    localparam int DEF_ADDR_W = 10;
    localparam int DEF_DEPTH  = 4;

    typedef enum logic [2:0] {IDLE, REQ, GAP, FULL, DRAIN} state_t;
endpackage

// File: rtl/instruction_prefetch_if.sv
// PC-stage, decoder and memory-controller signals of the prefetch stage.
// master = prefetch stage, slave = its environment.
interface instruction_prefetch_if #(
    parameter int DATA_W = ifetch_pkg::DEF_DATA_W,
    parameter int ADDR_W = ifetch_pkg::DEF_ADDR_W,
    parameter int DEPTH  = ifetch_pkg::DEF_DEPTH
) ();
    localparam int LVL_W = $clog2(DEPTH + 1);

    logic              DIR;
    logic [ADDR_W-1:0] data_in;
    logic              ack_prev;
    logic              halt;
    logic              DOR;
    logic [DATA_W-1:0] data_out;
    logic [ADDR_W-1:0] pc_out;
    logic              ack_from_next;
    logic [LVL_W-1:0]  level;
    logic              mem_en;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_di;
    logic [DATA_W-1:0] mem_do;
    logic              mem_do_ack;

    modport master (
        input  DIR, data_in, halt, ack_from_next, mem_do, mem_do_ack,
        output ack_prev, DOR, data_out, pc_out, level, mem_en, mem_addr, mem_di
    );
    modport slave (
        output DIR, data_in, halt, ack_from_next, mem_do, mem_do_ack,
        input  ack_prev, DOR, data_out, pc_out, level, mem_en, mem_addr, mem_di
    );
endinterface

// File: rtl/ifetch_fifo.sv
// Synchronous FIFO of fetched {pc, word} entries; flush beats push/pop.
module ifetch_fifo #(
    parameter int W     = 42,
    parameter int DEPTH = 4,
    localparam int PW   = $clog2(DEPTH),
    localparam int CW   = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          push,
    input  logic          pop,
    input  logic          flush,
    input  logic [W-1:0]  din,
    output logic [W-1:0]  head,
    output logic [CW-1:0] count
);
    logic [DEPTH-1:0][W-1:0] mem;
    logic [PW-1:0]           rd_ptr, wr_ptr;

    always_ff @(posedge clk) begin
        if (reset) begin
            mem    <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= wr_ptr + PW'(1);
            end
            if (pop)
                rd_ptr <= rd_ptr + PW'(1);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    assign head = mem[rd_ptr];
endmodule

// File: rtl/instruction_prefetch.sv
// Sequential instruction prefetcher: one outstanding read, DEPTH-entry queue to the decoder.
// Define IPREFETCH_REDIRECT_EN to accept DIR as a redirect outside IDLE (except DRAIN).
module instruction_prefetch
    import ifetch_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DEPTH  = DEF_DEPTH
) (
    input logic                    clk,
    input logic                    reset,
    instruction_prefetch_if.master bus
);
    localparam int LVL_W = $clog2(DEPTH + 1);
    localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(DEPTH);

    state_t              state;
    logic [ADDR_W-1:0]   pc, mem_addr_q;
    logic                ack_prev_q, mem_en_q, redir_pend;
    logic [LVL_W-1:0]    level_q;
    logic [ADDR_W+DATA_W-1:0] head;
    logic                dor, mem_ack, pop, push, flush, redirect;

    assign dor     = (level_q != '0);
    assign mem_ack = bus.mem_do_ack;
    assign pop     = bus.ack_from_next && dor && !bus.halt;

`ifdef IPREFETCH_REDIRECT_EN
    assign redirect = bus.DIR && !bus.halt && (state != IDLE) && (state != DRAIN);
`else
    assign redirect = 1'b0;
`endif

    assign push  = (state == REQ) && mem_ack && !bus.halt && !redirect;
    assign flush = bus.halt || redirect;

    ifetch_fifo #(.W(ADDR_W + DATA_W), .DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .flush (flush),
        .din   ({pc, bus.mem_do}),
        .head  (head),
        .count (level_q)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            pc         <= '0;
            ack_prev_q <= 1'b0;
            mem_en_q   <= 1'b0;
            mem_addr_q <= '0;
            redir_pend <= 1'b0;
        end else begin
            ack_prev_q <= 1'b0;
            if (bus.halt) begin
                // An unacknowledged read must still complete; its data is dropped in DRAIN.
                if ((state == REQ || state == DRAIN) && !mem_ack) begin
                    state <= DRAIN;
                end else begin
                    state    <= IDLE;
                    mem_en_q <= 1'b0;
                end
                redir_pend <= 1'b0;
            end else if (redirect) begin
                ack_prev_q <= 1'b1;
                pc         <= bus.data_in;
                if (state == REQ && !mem_ack) begin
                    state      <= DRAIN;
                    redir_pend <= 1'b1;
                end else begin
                    state      <= REQ;
                    mem_en_q   <= 1'b1;
                    mem_addr_q <= bus.data_in;
                end
            end else begin
                case (state)
                    IDLE: if (bus.DIR) begin
                        pc         <= bus.data_in;
                        ack_prev_q <= 1'b1;
                        mem_en_q   <= 1'b1;
                        mem_addr_q <= bus.data_in;
                        state      <= REQ;
                    end
                    REQ: if (mem_ack) begin
                        pc       <= pc + ADDR_W'(1);
                        mem_en_q <= 1'b0;
                        state    <= GAP;
                    end
                    GAP: if (level_q != LVL_FULL || pop) begin
                        mem_en_q   <= 1'b1;
                        mem_addr_q <= pc;
                        state      <= REQ;
                    end else begin
                        state <= FULL;
                    end
                    FULL: if (level_q != LVL_FULL) begin
                        mem_en_q   <= 1'b1;
                        mem_addr_q <= pc;
                        state      <= REQ;
                    end
                    DRAIN: if (mem_ack) begin
                        if (redir_pend) begin
                            mem_en_q   <= 1'b1;
                            mem_addr_q <= pc;
                            state      <= REQ;
                        end else begin
                            mem_en_q <= 1'b0;
                            state    <= IDLE;
                        end
                        redir_pend <= 1'b0;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    assign bus.ack_prev = ack_prev_q;
    assign bus.mem_en   = mem_en_q;
    assign bus.mem_addr = mem_addr_q;
    assign bus.mem_di   = '0;
    assign bus.level    = level_q;
    assign bus.DOR      = dor;
    assign bus.data_out = head[DATA_W-1:0];
    assign bus.pc_out   = head[DATA_W +: ADDR_W];
endmodule

// File: tb/tb_instruction_prefetch.sv
// Bench for instruction_prefetch: directed scenarios plus random traffic against a queue model.
module tb_instruction_prefetch;
    localparam int DATA_W = 32;
    localparam int ADDR_W = 10;
    localparam int DEPTH  = 4;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    instruction_prefetch_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) bus ();

    instruction_prefetch #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct packed {
        logic [ADDR_W-1:0] pc;
        logic [DATA_W-1:0] w;
    } ent_t;

    ent_t              q[$];
    int                total = 0, bad = 0;
    logic [ADDR_W-1:0] exp_addr = '0;
    bit                idle = 1, discard = 0, exp_ack = 0, en_low = 1;
    int                lat = 2, mcnt = 0, acks = 0;

    function automatic logic [DATA_W-1:0] word_of(input logic [ADDR_W-1:0] a);
        return 32'hA500_0000 ^ (32'(a) * 32'd2654435761);
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs();
        chk("level", 64'(bus.level), 64'(q.size()));
        chk("dor", 64'(bus.DOR), 64'(q.size() != 0));
        if (q.size() > 0) begin
            chk("pc_out", 64'(bus.pc_out), 64'(q[0].pc));
            chk("data_out", 64'(bus.data_out), 64'(q[0].w));
        end
        chk("ack_prev", 64'(bus.ack_prev), 64'(exp_ack));
        chk("mem_di", 64'(bus.mem_di), 64'(0));
        if (en_low) chk("mem_en_gap", 64'(bus.mem_en), 64'(0));
        if (bus.mem_en && !discard) chk("req_room", 64'(bus.level < DEPTH), 64'(1));
    endtask

    // Effect of the coming clock edge on the expected queue and stream position.
    task automatic model_update();
        bit acc;
        int n;
        acc     = bus.mem_en && bus.mem_do_ack;
        exp_ack = 0;
        en_low  = 0;
        if (reset) begin
            q.delete(); idle = 1; discard = 0; en_low = 1;
        end else if (bus.halt) begin
            q.delete(); idle = 1;
            discard = bus.mem_en && !bus.mem_do_ack;
        end else if (discard) begin
            if (acc) discard = 0;
        end else if (idle) begin
            if (bus.DIR) begin
                exp_addr = bus.data_in; idle = 0; exp_ack = 1;
            end
`ifdef IPREFETCH_REDIRECT_EN
        end else if (bus.DIR) begin
            q.delete(); exp_addr = bus.data_in; exp_ack = 1;
            discard = bus.mem_en && !bus.mem_do_ack;
`endif
        end else begin
            n = q.size();
            if (acc) begin
                chk("mem_addr", 64'(bus.mem_addr), 64'(exp_addr));
                chk("no_overflow", 64'(n < DEPTH), 64'(1));
                q.push_back(ent_t'{exp_addr, word_of(exp_addr)});
                exp_addr = exp_addr + 1'b1;
                en_low   = 1;
                acks++;
            end
            if (bus.ack_from_next && n > 0) void'(q.pop_front());
        end
    endtask

    // Memory controller: ack after lat+1 cycles of mem_en, single-cycle ack pulse.
    task automatic responder();
        if (reset || bus.mem_do_ack) begin
            bus.mem_do_ack = 0; mcnt = 0;
        end else if (bus.mem_en) begin
            mcnt++;
            if (mcnt > lat) begin
                bus.mem_do_ack = 1; bus.mem_do = word_of(bus.mem_addr); mcnt = 0;
            end
        end else begin
            mcnt = 0;
        end
    endtask

    task automatic cycle();
        @(negedge clk);
        check_outputs();
        model_update();
        @(posedge clk);
        #1;
        responder();
    endtask

    task automatic start(input logic [ADDR_W-1:0] a);
        bus.DIR = 1; bus.data_in = a;
        cycle();
        bus.DIR = 0;
    endtask

    task automatic drain();
        int n;
        bus.halt = 1;
        cycle();
        bus.halt = 0;
        n = 0;
        while ((discard || bus.mem_en) && n < 20) begin cycle(); n++; end
        chk("drain_timeout", 64'(n < 20), 64'(1));
    endtask

    initial begin
        int n, a0;
        logic [ADDR_W-1:0] seen_a[$], seen_p[$], hd;
        bit found;

        reset = 1;
        bus.DIR = 0; bus.data_in = '0; bus.halt = 0; bus.ack_from_next = 0;
        bus.mem_do = '0; bus.mem_do_ack = 0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ack_prev", 64'(bus.ack_prev), 64'(0));
        chk("rst_mem_en", 64'(bus.mem_en), 64'(0));
        chk("rst_mem_addr", 64'(bus.mem_addr), 64'(0));
        chk("rst_dor", 64'(bus.DOR), 64'(0));
        chk("rst_data_out", 64'(bus.data_out), 64'(0));
        chk("rst_pc_out", 64'(bus.pc_out), 64'(0));
        chk("rst_level", 64'(bus.level), 64'(0));
        reset = 0;

        // Fill to DEPTH without consuming, then one pop restarts the stream.
        lat = 2;
        start(10'h010);
        chk("t1_ack_prev", 64'(bus.ack_prev), 64'(1));
        chk("t1_mem_en", 64'(bus.mem_en), 64'(1));
        chk("t1_first_addr", 64'(bus.mem_addr), 64'(10'h010));
        n = 0;
        while (bus.level != DEPTH && n < 80) begin cycle(); n++; end
        chk("t1_fill_timeout", 64'(n < 80), 64'(1));
        chk("t1_head_pc", 64'(bus.pc_out), 64'(10'h010));
        repeat (8) begin cycle(); chk("t1_full_no_req", 64'(bus.mem_en), 64'(0)); end
        bus.ack_from_next = 1;
        cycle();
        bus.ack_from_next = 0;
        n = 0;
        while (!bus.mem_en && n < 10) begin cycle(); n++; end
        chk("t1_refill_lat", 64'(n), 64'(1));
        chk("t1_refill_addr", 64'(bus.mem_addr), 64'(10'h014));
        drain();

        // Address wrap at the top of the PC space.
        bus.ack_from_next = 1;
        start(10'h3FE);
        n = 0;
        while ((seen_a.size() < 3 || seen_p.size() < 3) && n < 60) begin
            if (bus.mem_en && bus.mem_do_ack) seen_a.push_back(bus.mem_addr);
            if (bus.DOR) seen_p.push_back(bus.pc_out);
            cycle(); n++;
        end
        chk("wrap_timeout", 64'(n < 60), 64'(1));
        chk("wrap_a0", 64'(seen_a[0]), 64'(10'h3FE));
        chk("wrap_a1", 64'(seen_a[1]), 64'(10'h3FF));
        chk("wrap_a2", 64'(seen_a[2]), 64'(10'h000));
        chk("wrap_p2", 64'(seen_p[2]), 64'(10'h000));
        bus.ack_from_next = 0;
        drain();

        // Pop and push on the same edge at level 2.
        lat = 1; found = 0;
        start(10'h040);
        n = 0;
        while (!found && n < 60) begin
            if (bus.level == 2 && bus.mem_do_ack) begin
                hd = bus.pc_out;
                bus.ack_from_next = 1;
                cycle();
                bus.ack_from_next = 0;
                chk("pp_level", 64'(bus.level), 64'(2));
                chk("pp_head", 64'(bus.pc_out), 64'(hd + 1'b1));
                found = 1;
            end else begin
                cycle(); n++;
            end
        end
        chk("pp_found", 64'(found), 64'(1));
        drain();

        // halt while a request is outstanding: request completes, data dropped.
        lat = 5;
        start(10'h080);
        n = 0;
        while (!(bus.level >= 1 && bus.mem_en && !bus.mem_do_ack) && n < 60) begin cycle(); n++; end
        chk("halt_setup", 64'(n < 60), 64'(1));
        bus.halt = 1;
        cycle();
        bus.halt = 0;
        chk("halt_level", 64'(bus.level), 64'(0));
        chk("halt_en_held", 64'(bus.mem_en), 64'(1));
        n = 0;
        while (!bus.mem_do_ack && n < 20) begin cycle(); n++; end
        cycle();
        chk("halt_en_drop", 64'(bus.mem_en), 64'(0));
        chk("halt_no_data", 64'(bus.DOR), 64'(0));
        start(10'h0A0);
        chk("halt_idle_accept", 64'(bus.ack_prev), 64'(1));
        drain();

        // DIR while streaming at 0x013.
        lat = 2;
        bus.ack_from_next = 1;
        start(10'h010);
        n = 0;
        while (!(bus.mem_en && bus.mem_addr == 10'h013 && !bus.mem_do_ack) && n < 80) begin cycle(); n++; end
        chk("redir_setup", 64'(n < 80), 64'(1));
        bus.DIR = 1; bus.data_in = 10'h200;
        cycle();
        bus.DIR = 0;
`ifdef IPREFETCH_REDIRECT_EN
        chk("redir_ack", 64'(bus.ack_prev), 64'(1));
        n = 0;
        while (!bus.DOR && n < 30) begin cycle(); n++; end
        chk("redir_first_pc", 64'(bus.pc_out), 64'(10'h200));
`else
        chk("redir_ignored", 64'(bus.ack_prev), 64'(0));
        n = 0;
        while (!(bus.mem_en && bus.mem_do_ack) && n < 20) begin cycle(); n++; end
        chk("redir_cont_013", 64'(bus.mem_addr), 64'(10'h013));
        cycle();
        n = 0;
        while (!(bus.mem_en && bus.mem_do_ack) && n < 20) begin cycle(); n++; end
        chk("redir_cont_014", 64'(bus.mem_addr), 64'(10'h014));
`endif
        bus.ack_from_next = 0;
        drain();

        // Reset in the middle of a request.
        lat = 6;
        start(10'h100);
        reset = 1;
        cycle();
        chk("rst_mid_en", 64'(bus.mem_en), 64'(0));
        cycle();
        reset = 0;

        // Random traffic.
        a0 = acks;
        for (int i = 0; i < 2500; i++) begin
            lat               = $urandom_range(0, 3);
            bus.ack_from_next = ($urandom_range(0, 1) == 1);
            bus.halt          = ($urandom_range(0, 63) == 0);
            bus.DIR           = ($urandom_range(0, 7) == 0);
            bus.data_in       = ADDR_W'($urandom);
            cycle();
        end
        bus.DIR = 0; bus.halt = 0; bus.ack_from_next = 0;
        chk("rand_progress", 64'((acks - a0) > 100), 64'(1));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
